seq_ctrl: RTL and testbench

SEQ_CTRL -- requirements
Module: seq_ctrl

---
 rtl/seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_seq_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_ctrl.sv
// seq_ctrl: three-key sequence counter (up / down / run-pause) with timed auto-advance.
// Every key is synchronized, debounced and reduced to a one-cycle press pulse before use.

module seq_ctrl_key #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // NOTE: every variable gets a default at the top of always_comb, so no latch is inferred.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_TC) begin
        level_d = sync_q[1];
        press_d = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

module seq_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STEP_CYCLES     = 25000000,
  parameter int MAX_SEQ         = 99
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       KEY1,
  input  logic       KEY2,
  input  logic       KEY3,
  output logic [6:0] seq_num,
  output logic       running,
  output logic       step_pulse
);

  localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_TC  = PW'(STEP_CYCLES - 1);
  localparam logic [6:0]    SEQ_MAX = 7'(MAX_SEQ);

  if (MAX_SEQ < 1 || MAX_SEQ > 127) begin : g_bad_max_seq
    $error("seq_ctrl: MAX_SEQ must be in 1..127");
  end

  logic [2:0] key_n;
  logic [2:0] press;

  assign key_n = {KEY3, KEY2, KEY1};

  for (genvar i = 0; i < 3; i++) begin : g_key
    seq_ctrl_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clk   (CLOCK_50),
      .rst_n (RESET_N),
      .key_n (key_n[i]),
      .press (press[i])
    );
  end

  logic [6:0]    seq_q, seq_d, seq_inc, seq_dec;
  logic          running_q, running_d;
  logic          step_q, step_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          up_ev, dn_ev, manual, tc;

  always_comb begin
    up_ev     = press[0];
    dn_ev     = press[1];
    manual    = up_ev | dn_ev;
    tc        = running_q && (presc_q == PRE_TC);
    seq_inc   = (seq_q == SEQ_MAX) ? 7'd0 : seq_q + 7'd1;
    seq_dec   = (seq_q == 7'd0) ? SEQ_MAX : seq_q - 7'd1;
    seq_d     = seq_q;
    step_d    = 1'b0;
    running_d = running_q ^ press[2];
    presc_d   = '0;

    // Any manual event, even a cancelled up+down pair, restarts the auto-advance period.
    if (running_q && !manual && !tc) presc_d = presc_q + 1'b1;

    if (up_ev && !dn_ev) begin
      seq_d  = seq_inc;
      step_d = 1'b1;
    end else if (dn_ev && !up_ev) begin
      seq_d  = seq_dec;
      step_d = 1'b1;
    end else if (tc && !manual) begin
      seq_d  = seq_inc;
      step_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      seq_q     <= '0;
      running_q <= 1'b0;
      step_q    <= 1'b0;
      presc_q   <= '0;
    end else begin
      seq_q     <= seq_d;
      running_q <= running_d;
      step_q    <= step_d;
      presc_q   <= presc_d;
    end
  end

  assign seq_num    = seq_q;
  assign running    = running_q;
  assign step_pulse = step_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Scoreboard bench for seq_ctrl: each expected seq_num value is queued when stimulus is
// driven and compared when step_pulse fires; timing and cancel cases are checked directly.

module tb_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:1] keys;
  logic [6:0] seq_num;
  logic       running;
  logic       step_pulse;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int model_seq = 0;
  int exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  seq_ctrl #(.DEBOUNCE_CYCLES(4), .STEP_CYCLES(8), .MAX_SEQ(99)) dut (
    .CLOCK_50   (clk),
    .RESET_N    (rst_n),
    .KEY1       (keys[1]),
    .KEY2       (keys[2]),
    .KEY3       (keys[3]),
    .seq_num    (seq_num),
    .running    (running),
    .step_pulse (step_pulse)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  function automatic int nxt(input int v);
    return (v == 99) ? 0 : v + 1;
  endfunction

  function automatic int prv(input int v);
    return (v == 0) ? 99 : v - 1;
  endfunction

  task automatic expect_up();
    model_seq = nxt(model_seq);
    exp_q.push_back(model_seq);
  endtask

  task automatic expect_dn();
    model_seq = prv(model_seq);
    exp_q.push_back(model_seq);
  endtask

  task automatic press(input int k);
    keys[k] = 1'b0;
    repeat (12) @(negedge clk);
    keys[k] = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_pulse(input int budget, output int at);
    at = -1000;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (step_pulse) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_running(input logic lvl, input int budget, output int at);
    at = -1000;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (running == lvl) begin
        at = cyc;
        break;
      end
    end
  endtask

  // Scoreboard side: sampled 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    if (rst_n && step_pulse) begin
      pulse_cnt++;
      if (exp_q.size() == 0) check("spurious_step", step_pulse, 0);
      else check("step_seq", seq_num, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t0, at, a1, a2, a3, t_run, t_off, p0;

    rst_n = 1'b0;
    keys  = 3'b111;
    repeat (3) @(negedge clk);
    check("rst_seq", seq_num, 0);
    check("rst_running", running, 0);
    check("rst_step", step_pulse, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single clean press: one step, 6..8 cycles after the fall.
    expect_up();
    p0 = pulse_cnt;
    keys[1] = 1'b0;
    t0 = cyc;
    wait_pulse(20, at);
    check("up_latency_ok", (at - t0 >= 6) && (at - t0 <= 8), 1);
    repeat (13) @(negedge clk);
    keys[1] = 1'b1;
    repeat (15) @(negedge clk);
    check("up_seq", seq_num, 1);
    check("up_once", pulse_cnt - p0, 1);

    // Wrap in both directions.
    expect_dn(); press(2);
    expect_dn(); press(2);
    check("down_to_99", seq_num, 99);
    expect_up(); press(1);
    check("wrap_up", seq_num, 0);
    expect_dn(); press(2);
    check("wrap_down", seq_num, 99);
    expect_up(); press(1);
    check("back_to_0", seq_num, model_seq);

    // Bounce shorter than the debounce window: no event.
    p0 = pulse_cnt;
    for (int i = 0; i < 15; i++) begin
      keys[1] = ~keys[1];
      repeat (2) @(negedge clk);
    end
    keys[1] = 1'b1;
    repeat (20) @(negedge clk);
    check("bounce_seq", seq_num, model_seq);
    check("bounce_pulses", pulse_cnt - p0, 0);

    // Run: auto steps every 8 cycles, then pause freezes the count.
    expect_up(); expect_up(); expect_up();
    keys[3] = 1'b0;
    wait_running(1'b1, 20, t_run);
    keys[3] = 1'b1;
    check("run_on", running, 1);
    wait_pulse(12, a1);
    check("auto_first", a1 - t_run, 8);
    wait_pulse(12, a2);
    check("auto_period1", a2 - a1, 8);
    wait_pulse(12, a3);
    check("auto_period2", a3 - a2, 8);
    keys[3] = 1'b0;
    wait_running(1'b0, 20, t_off);
    keys[3] = 1'b1;
    check("run_off", running, 0);
    p0 = pulse_cnt;
    repeat (40) @(negedge clk);
    check("paused_seq", seq_num, model_seq);
    check("paused_pulses", pulse_cnt - p0, 0);

    // Up+down landing on the terminal count: no change, next auto step 8 cycles later.
    expect_up();
    keys[3] = 1'b0;
    wait_running(1'b1, 20, t_run);
    keys[3] = 1'b1;
    @(negedge clk);
    keys[1] = 1'b0;
    keys[2] = 1'b0;
    repeat (8) @(negedge clk);
    keys[1] = 1'b1;
    keys[2] = 1'b1;
    check("cancel_hold", seq_num, prv(model_seq));
    wait_pulse(20, at);
    check("cancel_next_auto", at - t_run, 16);
    keys[3] = 1'b0;
    wait_running(1'b0, 20, t_off);
    keys[3] = 1'b1;
    check("cancel_pause", running, 0);
    repeat (12) @(negedge clk);

    // Run up to 42, then reset mid-debounce.
    while (model_seq != 42) expect_up();
    keys[3] = 1'b0;
    wait_running(1'b1, 20, t_run);
    keys[3] = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (seq_num == 42) break;
    end
    check("reach_42", seq_num, 42);
    check("sb_empty_42", exp_q.size(), 0);
    keys[1] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_seq", seq_num, 0);
    check("abort_running", running, 0);
    check("abort_step", step_pulse, 0);
    keys[1] = 1'b1;
    model_seq = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    p0 = pulse_cnt;
    repeat (30) @(negedge clk);
    check("post_rst_seq", seq_num, 0);
    check("post_rst_running", running, 0);
    check("post_rst_pulses", pulse_cnt - p0, 0);

    // Key held low through reset release: exactly one event.
    keys[1] = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    p0 = pulse_cnt;
    expect_up();
    repeat (20) @(negedge clk);
    keys[1] = 1'b1;
    repeat (15) @(negedge clk);
    check("held_rst_seq", seq_num, 1);
    check("held_rst_pulses", pulse_cnt - p0, 1);

    check("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
